baby_ram_arbiter: RTL and testbench

//  Shares the single external 32x32 store bus between the Manchester Baby core and a host

---
 rtl/baby_ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_baby_ram_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baby_ram_arbiter.sv
// baby_ram_arbiter
//   Shares the external 32x32 store bus between the Manchester Baby core and a
//   host load/debug port. While the core owns the bus the ram_* pins mirror the
//   core. A host command freezes the core (cpu_hold_o), the bus is turned
//   around, then the host runs one or more accesses. The arbiter releases the
//   bus back to the core through a one-cycle idle REL state. Host bursts are
//   capped at HOST_BURST accesses per grant unless the core is halted.
//
// Ports
//   clock, reset_i                       clock, synchronous active-high reset
//   cpu_addr_i/cpu_rw_en_i/cpu_data_i    core store request
//   cpu_data_o                           store read data to core
//   cpu_stop_i                           core halted (lifts burst limit)
//   cpu_hold_o                           registered core freeze request
//   host_valid_i/host_ready_o            host command handshake
//   host_we_i/host_addr_i/host_wdata_i   host command
//   host_done_o/host_rdata_o             one-cycle completion pulse, read data
//   ram_addr_o/ram_rw_en_o/ram_data_o    store bus outputs
//   ram_data_i                           store read data
module baby_ram_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int HOST_BURST = 4
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_rw_en_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  input  logic              cpu_stop_i,
  output logic              cpu_hold_o,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_done_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rw_en_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int CNT_W = $clog2(HOST_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(HOST_BURST);

  typedef enum logic [2:0] {
    S_CPU  = 3'd0,
    S_HOLD = 3'd1,
    S_TURN = 3'd2,
    S_ACC  = 3'd3,
    S_REL  = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  burst_cnt;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              accept;

  assign cpu_data_o = ram_data_i;

  // Host may take a new command in CPU, or in ACC while under the burst cap.
  // A halted core cannot be starved, so the cap is ignored then.
  always_comb begin
    host_ready_o = 1'b0;
    case (state)
      S_CPU:   host_ready_o = 1'b1;
      S_ACC:   host_ready_o = (burst_cnt < BURST_MAX) || cpu_stop_i;
      default: host_ready_o = 1'b0;
    endcase
  end

  assign accept = host_valid_i & host_ready_o;

  // Bus mux. HOLD still passes the core through so its in-flight cycle
  // completes; TURN and REL park the bus in read so two drivers never
  // overlap on the tri-state data lines.
  always_comb begin
    ram_addr_o  = cpu_addr_i;
    ram_rw_en_o = cpu_rw_en_i;
    ram_data_o  = cpu_data_i;
    case (state)
      S_TURN, S_REL: begin
        ram_addr_o  = cmd_addr;
        ram_rw_en_o = 1'b0;
        ram_data_o  = '0;
      end
      S_ACC: begin
        ram_addr_o  = cmd_addr;
        ram_rw_en_o = cmd_we;
        ram_data_o  = cmd_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state        <= S_CPU;
      cpu_hold_o   <= 1'b0;
      host_done_o  <= 1'b0;
      host_rdata_o <= '0;
      burst_cnt    <= '0;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
    end else begin
      // Every ACC cycle is one completed access, reported next cycle.
      host_done_o <= (state == S_ACC);
      if (state == S_ACC && !cmd_we) begin
        host_rdata_o <= ram_data_i;
      end

      case (state)
        S_CPU: begin
          if (accept) begin
            cmd_we     <= host_we_i;
            cmd_addr   <= host_addr_i;
            cmd_wdata  <= host_wdata_i;
            burst_cnt  <= CNT_W'(1);
            cpu_hold_o <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: state <= S_TURN;
        S_TURN: state <= S_ACC;
        S_ACC: begin
          if (accept) begin
            cmd_we    <= host_we_i;
            cmd_addr  <= host_addr_i;
            cmd_wdata <= host_wdata_i;
            if (burst_cnt < BURST_MAX) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
            // A direction change needs a turnaround cycle on the data bus.
            state <= (host_we_i == cmd_we) ? S_ACC : S_TURN;
          end else begin
            state <= S_REL;
          end
        end
        S_REL: begin
          cpu_hold_o <= 1'b0;
          burst_cnt  <= '0;
          state      <= S_CPU;
        end
        default: begin
          cpu_hold_o <= 1'b0;
          state      <= S_CPU;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baby_ram_arbiter.sv
module tb_baby_ram_arbiter;

  localparam int HOST_BURST = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [4:0]  cpu_addr_i = '0;
  logic        cpu_rw_en_i = 1'b0;
  logic [31:0] cpu_data_i = '0;
  logic [31:0] cpu_data_o;
  logic        cpu_stop_i = 1'b0;
  logic        cpu_hold_o;
  logic        host_valid_i = 1'b0;
  logic        host_ready_o;
  logic        host_we_i = 1'b0;
  logic [4:0]  host_addr_i = '0;
  logic [31:0] host_wdata_i = '0;
  logic        host_done_o;
  logic [31:0] host_rdata_o;
  logic [4:0]  ram_addr_o;
  logic        ram_rw_en_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;

  always #5 clk = ~clk;

  baby_ram_arbiter #(.ADDR_W(5), .DATA_W(32), .HOST_BURST(HOST_BURST)) dut (
    .clock(clk), .reset_i(reset_i),
    .cpu_addr_i(cpu_addr_i), .cpu_rw_en_i(cpu_rw_en_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stop_i(cpu_stop_i), .cpu_hold_o(cpu_hold_o),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_done_o(host_done_o),
    .host_rdata_o(host_rdata_o), .ram_addr_o(ram_addr_o), .ram_rw_en_o(ram_rw_en_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  // Store model: asynchronous read, write on clock edge.
  logic [31:0] mem [32];
  logic        mem_clear = 1'b1;
  assign ram_data_i = mem[ram_addr_o];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (ram_rw_en_o) begin
      mem[ram_addr_o] <= ram_data_o;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    host_valid_i = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick();
    while (cpu_hold_o && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(cpu_hold_o), 32'd0);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {16'hC0DE, b, ~b};
  endfunction

  // Core-only table
  typedef struct {
    logic [4:0]  addr;
    logic        rw;
    logic [31:0] data;
    logic [4:0]  e_addr;
    logic        e_rw;
    logic [31:0] e_data;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;
  vec_t vecs[9];

  // Transaction-level reference for the random phase
  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_mem [32];

  task automatic handle_done();
    exp_t e;
    if (host_done_o) begin
      check("rnd_done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!e.we) check("rnd_rdata", host_rdata_o, e.data);
      end
    end
  endtask

  int idx, ndone, first_c, wlast_c, last_c;
  int phase, dones, lows;
  int grant_dones;
  logic stop_in_grant, prev_hold;

  initial begin
    vecs[0] = '{5'd3,  1'b1, 32'h11111111, 5'd3,  1'b1, 32'h11111111, 1'b0, 32'h0};
    vecs[1] = '{5'd31, 1'b1, 32'hA5A5A5A5, 5'd31, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[2] = '{5'd3,  1'b0, 32'h0,        5'd3,  1'b0, 32'h0,        1'b1, 32'h11111111};
    vecs[3] = '{5'd31, 1'b0, 32'h12,       5'd31, 1'b0, 32'h12,       1'b1, 32'hA5A5A5A5};
    vecs[4] = '{5'd0,  1'b1, 32'hFFFFFFFF, 5'd0,  1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[5] = '{5'd0,  1'b0, 32'h0,        5'd0,  1'b0, 32'h0,        1'b1, 32'hFFFFFFFF};
    vecs[6] = '{5'd1,  1'b0, 32'h0,        5'd1,  1'b0, 32'h0,        1'b1, 32'h00000000};
    vecs[7] = '{5'd3,  1'b1, 32'h0,        5'd3,  1'b1, 32'h0,        1'b0, 32'h0};
    vecs[8] = '{5'd3,  1'b0, 32'h7,        5'd3,  1'b0, 32'h7,        1'b1, 32'h00000000};

    do_reset();
    mem_clear = 1'b0;
    settle();
    check("reset_hold", 32'(cpu_hold_o), 32'd0);
    check("reset_done", 32'(host_done_o), 32'd0);
    check("reset_rdata", host_rdata_o, 32'd0);
    check("reset_ready", 32'(host_ready_o), 32'd1);

    // Test 1: core traffic only
    for (int i = 0; i < 9; i++) begin
      cpu_addr_i = vecs[i].addr;
      cpu_rw_en_i = vecs[i].rw;
      cpu_data_i = vecs[i].data;
      settle();
      check("t1_addr", 32'(ram_addr_o), 32'(vecs[i].e_addr));
      check("t1_rw", 32'(ram_rw_en_o), 32'(vecs[i].e_rw));
      check("t1_data", ram_data_o, vecs[i].e_data);
      check("t1_hold", 32'(cpu_hold_o), 32'd0);
      check("t1_done", 32'(host_done_o), 32'd0);
      if (vecs[i].chk_rd) check("t1_rd", cpu_data_o, vecs[i].e_rd);
      tick();
    end

    // Test 2: single host write
    cpu_rw_en_i = 1'b0; cpu_addr_i = 5'd1; cpu_data_i = 32'h0;
    host_valid_i = 1'b1; host_we_i = 1'b1; host_addr_i = 5'd5; host_wdata_i = 32'hDEADBEEF;
    settle();
    check("t2_ready", 32'(host_ready_o), 32'd1);
    tick();
    host_valid_i = 1'b0;
    settle();
    check("t2_hold_hold", 32'(cpu_hold_o), 32'd1);
    check("t2_hold_ready", 32'(host_ready_o), 32'd0);
    check("t2_hold_addr", 32'(ram_addr_o), 32'd1);
    tick();
    check("t2_turn_rw", 32'(ram_rw_en_o), 32'd0);
    check("t2_turn_addr", 32'(ram_addr_o), 32'd5);
    tick();
    check("t2_acc_rw", 32'(ram_rw_en_o), 32'd1);
    check("t2_acc_addr", 32'(ram_addr_o), 32'd5);
    check("t2_acc_data", ram_data_o, 32'hDEADBEEF);
    check("t2_acc_done", 32'(host_done_o), 32'd0);
    tick();
    check("t2_rel_done", 32'(host_done_o), 32'd1);
    check("t2_rel_rw", 32'(ram_rw_en_o), 32'd0);
    check("t2_rel_hold", 32'(cpu_hold_o), 32'd1);
    tick();
    check("t2_cpu_hold", 32'(cpu_hold_o), 32'd0);
    check("t2_cpu_done", 32'(host_done_o), 32'd0);
    check("t2_mem", mem[5], 32'hDEADBEEF);

    // Test 6: core write during accept cycle and HOLD, then host read
    cpu_addr_i = 5'd7; cpu_rw_en_i = 1'b1; cpu_data_i = 32'h12345678;
    host_valid_i = 1'b1; host_we_i = 1'b0; host_addr_i = 5'd7;
    settle();
    check("t6_ready", 32'(host_ready_o), 32'd1);
    tick();
    host_valid_i = 1'b0;
    cpu_data_i = 32'hCAFEF00D;
    settle();
    check("t6_hold_rw", 32'(ram_rw_en_o), 32'd1);
    check("t6_hold_data", ram_data_o, 32'hCAFEF00D);
    tick();
    check("t6_turn_rw", 32'(ram_rw_en_o), 32'd0);
    tick();
    check("t6_acc_rw", 32'(ram_rw_en_o), 32'd0);
    check("t6_acc_addr", 32'(ram_addr_o), 32'd7);
    tick();
    check("t6_rel_done", 32'(host_done_o), 32'd1);
    check("t6_rel_rdata", host_rdata_o, 32'hCAFEF00D);
    cpu_rw_en_i = 1'b0;
    wait_idle("t6_idle");

    // Test 5: reset while a host write is in ACC
    host_valid_i = 1'b1; host_we_i = 1'b1; host_addr_i = 5'd9; host_wdata_i = 32'h55AA55AA;
    tick();
    host_valid_i = 1'b0;
    tick();
    tick();
    check("t5_acc_rw", 32'(ram_rw_en_o), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    cpu_rw_en_i = 1'b1; cpu_addr_i = 5'd2; cpu_data_i = 32'h0BADF00D;
    settle();
    check("t5_hold", 32'(cpu_hold_o), 32'd0);
    check("t5_done", 32'(host_done_o), 32'd0);
    check("t5_rw_follow1", 32'(ram_rw_en_o), 32'd1);
    check("t5_addr_follow", 32'(ram_addr_o), 32'd2);
    check("t5_ready", 32'(host_ready_o), 32'd1);
    cpu_rw_en_i = 1'b0;
    settle();
    check("t5_rw_follow0", 32'(ram_rw_en_o), 32'd0);
    tick();
    check("t5_no_done", 32'(host_done_o), 32'd0);

    // Test 3: core halted, 32 writes then 32 reads
    cpu_stop_i = 1'b1;
    idx = 0; ndone = 0; first_c = -1; wlast_c = -1; last_c = -1;
    for (int c = 0; c < 200 && ndone < 64; c++) begin
      if (host_done_o) begin
        if (ndone >= 32) check("t3_rdata", host_rdata_o, pat(ndone - 32));
        if (first_c < 0) first_c = c;
        if (ndone == 31) wlast_c = c;
        last_c = c;
        ndone++;
      end
      if (idx < 64) begin
        host_valid_i = 1'b1;
        host_we_i = (idx < 32);
        host_addr_i = 5'(idx % 32);
        host_wdata_i = pat(idx % 32);
      end else begin
        host_valid_i = 1'b0;
      end
      settle();
      if (host_valid_i && host_ready_o) idx++;
      tick();
    end
    host_valid_i = 1'b0;
    check("t3_done_count", 32'(ndone), 32'd64);
    check("t3_write_span", 32'(wlast_c - first_c), 32'd31);
    check("t3_total_span", 32'(last_c - first_c), 32'd64);
    wait_idle("t3_idle");

    // Test 4: core running, host always valid
    cpu_stop_i = 1'b0;
    host_valid_i = 1'b1; host_we_i = 1'b0; host_addr_i = 5'd4;
    phase = 0; dones = 0; lows = 0;
    for (int c = 0; c < 40 && phase < 3; c++) begin
      settle();
      case (phase)
        0: if (cpu_hold_o) phase = 1;
        1: begin
          if (host_done_o) dones++;
          if (!cpu_hold_o) begin
            phase = 2;
            lows = 1;
          end
        end
        2: if (cpu_hold_o) phase = 3; else lows++;
        default: ;
      endcase
      if (phase < 3) tick();
    end
    host_valid_i = 1'b0;
    check("t4_accesses", 32'(dones), 32'd4);
    check("t4_regrant", 32'(phase), 32'd3);
    check("t4_cpu_gap", 32'(lows >= 1), 32'd1);
    wait_idle("t4_idle");

    // Random traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = mem[i];
    exp_q.delete();
    grant_dones = 0; stop_in_grant = 1'b0; prev_hold = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) cpu_stop_i = 1'($urandom);
      handle_done();
      if (cpu_hold_o) begin
        if (host_done_o) grant_dones++;
        if (cpu_stop_i) stop_in_grant = 1'b1;
      end else begin
        if (prev_hold && !stop_in_grant)
          check("rnd_burst_limit", 32'(grant_dones <= HOST_BURST), 32'd1);
        grant_dones = 0;
        stop_in_grant = 1'b0;
      end
      prev_hold = cpu_hold_o;
      if (!host_valid_i && c < 1450 && $urandom_range(0, 2) != 0) begin
        host_valid_i = 1'b1;
        host_we_i = 1'($urandom);
        host_addr_i = 5'($urandom_range(0, 31));
        host_wdata_i = $urandom;
      end
      cpu_addr_i = 5'($urandom_range(0, 31));
      cpu_rw_en_i = 1'b0;
      cpu_data_i = $urandom;
      settle();
      if (!cpu_hold_o) begin
        check("rnd_mirror_addr", 32'(ram_addr_o), 32'(cpu_addr_i));
        check("rnd_mirror_rw", 32'(ram_rw_en_o), 32'(cpu_rw_en_i));
        check("rnd_mirror_data", ram_data_o, cpu_data_i);
        check("rnd_cpu_ready", 32'(host_ready_o), 32'd1);
      end
      if (host_valid_i && host_ready_o) begin
        if (host_we_i) begin
          model_mem[host_addr_i] = host_wdata_i;
          exp_q.push_back('{1'b1, 32'h0});
        end else begin
          exp_q.push_back('{1'b0, model_mem[host_addr_i]});
        end
        tick();
        host_valid_i = 1'b0;
      end else begin
        tick();
      end
    end
    host_valid_i = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      handle_done();
      tick();
    end
    check("rnd_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 32; i++) check("rnd_mem", mem[i], model_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
